// File: rtl/ifu_fetch_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ifu_fetch_if
// Description : Bundle for the fetch unit: instruction-memory read channel
//               plus the decode-side instruction handshake and next-PC input.
//               master = fetch unit view, slave = memory/decode view.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface ifu_fetch_if #(
  parameter int ADDR_W = 32
);
  // Instruction memory read channel
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  // Decode / retire side
  logic [ADDR_W-1:0] pc;
  logic [31:0]       inst;
  logic              inst_fault;
  logic              inst_valid;
  logic              inst_ready;
  logic [ADDR_W-1:0] npc;
  logic              npc_valid;

  modport master (
    output araddr, arvalid, rready, pc, inst, inst_fault, inst_valid,
    input  arready, rdata, rresp, rvalid, inst_ready, npc, npc_valid
  );

  modport slave (
    input  araddr, arvalid, rready, pc, inst, inst_fault, inst_valid,
    output arready, rdata, rresp, rvalid, inst_ready, npc, npc_valid
  );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ifu_fetch
// Description : Multi-cycle instruction fetch unit. Holds the architectural
//               PC, issues one read per instruction, hands the word to decode
//               and waits for the next PC once the instruction has retired.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module ifu_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,   // asynchronous, active-low
  ifu_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_OUT    = 3'd3,
    S_WAITPC = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_inst;
  logic              r_fault;
  logic              w_take_resp;
  logic              w_take_npc;

  // State register; reset forces all handshake outputs low immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic; responses and next PCs are only honoured in their own state
  always_comb begin
    w_next_state = r_state;
    w_take_resp  = 1'b0;
    w_take_npc   = 1'b0;
    case (r_state)
      S_IDLE:   w_next_state = S_ADDR;
      S_ADDR:   if (bus.arready) w_next_state = S_DATA;
      S_DATA: begin
        if (bus.rvalid) begin
          w_take_resp  = 1'b1;
          w_next_state = S_OUT;
        end
      end
      S_OUT:    if (bus.inst_ready) w_next_state = S_WAITPC;
      S_WAITPC: begin
        if (bus.npc_valid) begin
          w_take_npc   = 1'b1;
          w_next_state = S_ADDR;
        end
      end
      default:  w_next_state = S_IDLE;
    endcase
  end

  // PC and fetched-instruction registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_inst  <= 32'h0;
      r_fault <= 1'b0;
    end else begin
      if (w_take_npc) r_pc <= bus.npc;
      if (w_take_resp) begin
        r_inst  <= bus.rdata;
        r_fault <= (bus.rresp != 2'b00);
      end
    end
  end

  // Handshake outputs are pure state decodes so they glitch-free track reset
  assign bus.arvalid    = (r_state == S_ADDR);
  assign bus.rready     = (r_state == S_DATA);
  assign bus.inst_valid = (r_state == S_OUT);
  assign bus.araddr     = r_pc;
  assign bus.pc         = r_pc;
  assign bus.inst       = r_inst;
  assign bus.inst_fault = r_fault;

endmodule
`default_nettype wire
